// File: rtl/return_addr_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack_pkg
// Description : Shared constants and types for the return-address stack:
//               overflow policy codes and the per-cycle operation decode.
// Revision    : 1.0 - initial release
// ============================================================================
package return_addr_stack_pkg;

    // Overflow policy selector values for OVERFLOW_MODE
    localparam int RAS_MODE_WRAP     = 0;
    localparam int RAS_MODE_SATURATE = 1;

    // Byte distance from a link instruction to its return point
    localparam int unsigned C_LINK_BYTES = 4;

    // Operation selected for the current edge, already priority-resolved
    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_FLUSH   = 3'd1,
        OP_REPLACE = 3'd2,
        OP_PUSH    = 3'd3,
        OP_POP     = 3'd4
    } ras_op_e;

    // flush beats push+pop, which beats push, which beats pop
    function automatic ras_op_e decode_op(input logic push, input logic pop,
                                          input logic flush);
        ras_op_e op;
        if (flush)            op = OP_FLUSH;
        else if (push && pop) op = OP_REPLACE;
        else if (push)        op = OP_PUSH;
        else if (pop)         op = OP_POP;
        else                  op = OP_IDLE;
        return op;
    endfunction

endpackage : return_addr_stack_pkg
`default_nettype wire

// File: rtl/return_addr_stack_storage.sv
`default_nettype none
// ============================================================================
// Module      : ras_storage
// Description : DEPTH x ADDR_WIDTH register file, one synchronous write port
//               and one asynchronous read port. All words clear on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_storage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_idx,
    input  logic [ADDR_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_idx,
    output logic [ADDR_WIDTH-1:0] rd_data
);

    logic [ADDR_WIDTH-1:0] r_mem [DEPTH];

    // Word storage: cleared on reset, single write per edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_idx];

endmodule : ras_storage
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack
// Description : Return-address stack for the fetch unit. Link branches push
//               PC+4, returns pop it; circular storage with wrap or saturate
//               overflow policy, flush, sticky overflow and underflow pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int OVERFLOW_MODE = RAS_MODE_WRAP,
    localparam int PTR_W        = $clog2(DEPTH),
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic                  pop,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] top_addr,
    output logic                  top_valid,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      r_tos;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [PTR_W-1:0]      w_next_tos;
    logic [CNT_W-1:0]      w_next_count;
    logic                  w_next_overflow;
    logic                  w_next_underflow;
    logic                  w_wr_en;
    logic [PTR_W-1:0]      w_wr_idx;
    logic [PTR_W-1:0]      w_tos_inc;
    logic [ADDR_WIDTH-1:0] w_link_addr;
    logic [ADDR_WIDTH-1:0] w_rd_data;
    logic                  w_empty;
    logic                  w_full;
    ras_op_e               w_op;

    // Return address wraps naturally modulo 2^ADDR_WIDTH
    assign w_link_addr = push_pc + ADDR_WIDTH'(C_LINK_BYTES);
    assign w_tos_inc   = r_tos + PTR_W'(1);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == C_FULL);
    assign w_op        = decode_op(push, pop, flush);

    // Next-state for pointer, occupancy and flags, plus the storage write
    always_comb begin
        w_next_tos       = r_tos;
        w_next_count     = r_count;
        w_next_overflow  = r_overflow;
        w_next_underflow = 1'b0;
        w_wr_en          = 1'b0;
        w_wr_idx         = r_tos;
        case (w_op)
            OP_FLUSH: begin
                w_next_count    = '0;
                w_next_overflow = 1'b0;
            end
            OP_REPLACE: begin
                // jalr through $ra: overwrite top; on empty it is a plain push
                w_wr_en = 1'b1;
                if (w_empty) begin
                    w_next_tos   = w_tos_inc;
                    w_wr_idx     = w_tos_inc;
                    w_next_count = CNT_W'(1);
                end
            end
            OP_PUSH: begin
                if (!w_full) begin
                    w_next_tos   = w_tos_inc;
                    w_wr_idx     = w_tos_inc;
                    w_wr_en      = 1'b1;
                    w_next_count = r_count + CNT_W'(1);
                end else begin
                    w_next_overflow = 1'b1;
                    // With a full ring the slot above top holds the oldest entry
                    if (OVERFLOW_MODE == RAS_MODE_WRAP) begin
                        w_next_tos = w_tos_inc;
                        w_wr_idx   = w_tos_inc;
                        w_wr_en    = 1'b1;
                    end
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_next_underflow = 1'b1;
                end else begin
                    w_next_tos   = r_tos - PTR_W'(1);
                    w_next_count = r_count - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tos       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_tos       <= w_next_tos;
            r_count     <= w_next_count;
            r_overflow  <= w_next_overflow;
            r_underflow <= w_next_underflow;
        end
    end

    ras_storage #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en),
        .wr_idx  (w_wr_idx),
        .wr_data (w_link_addr),
        .rd_idx  (r_tos),
        .rd_data (w_rd_data)
    );

    assign top_addr  = w_empty ? '0 : w_rd_data;
    assign top_valid = !w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : return_addr_stack
`default_nettype wire

// File: tb/tb_return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_addr_stack
// Description : Scoreboard bench for return_addr_stack (DEPTH=4), one
//               instance per overflow policy, checked against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_return_addr_stack;

    localparam int AW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic [AW-1:0] push_pc = '0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;

    logic [AW-1:0] ta_w, ta_s;
    logic          tv_w, tv_s, ov_w, ov_s, uf_w, uf_s;
    logic [2:0]    cnt_w, cnt_s;

    return_addr_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .OVERFLOW_MODE(0)) dut_wrap (
        .clk(clk), .reset(reset), .push(push), .push_pc(push_pc), .pop(pop),
        .flush(flush), .top_addr(ta_w), .top_valid(tv_w), .count(cnt_w),
        .overflow(ov_w), .underflow(uf_w));

    return_addr_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .OVERFLOW_MODE(1)) dut_sat (
        .clk(clk), .reset(reset), .push(push), .push_pc(push_pc), .pop(pop),
        .flush(flush), .top_addr(ta_s), .top_valid(tv_s), .count(cnt_s),
        .overflow(ov_s), .underflow(uf_s));

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] ta_w;
        logic [AW-1:0] ta_s;
        int            n_w;
        int            n_s;
        logic          ov_w;
        logic          ov_s;
        logic          uf;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] mq_w[$];
    logic [AW-1:0] mq_s[$];
    logic          m_ov_w = 1'b0;
    logic          m_ov_s = 1'b0;
    logic          m_uf   = 1'b0;
    int            n_checks = 0;
    int            n_bad    = 0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a stack is a list whose last element is the top
    task automatic model_step(input logic rs, input logic p, input logic [AW-1:0] pc,
                              input logic po, input logic fl);
        logic [AW-1:0] v;
        v    = pc + 32'd4;
        m_uf = 1'b0;
        if (rs || fl) begin
            mq_w.delete(); mq_s.delete();
            m_ov_w = 1'b0; m_ov_s = 1'b0;
        end else if (p && po) begin
            if (mq_w.size() == 0) mq_w.push_back(v); else mq_w[mq_w.size()-1] = v;
            if (mq_s.size() == 0) mq_s.push_back(v); else mq_s[mq_s.size()-1] = v;
        end else if (p) begin
            if (mq_w.size() == D) begin void'(mq_w.pop_front()); m_ov_w = 1'b1; end
            mq_w.push_back(v);
            if (mq_s.size() == D) m_ov_s = 1'b1; else mq_s.push_back(v);
        end else if (po) begin
            if (mq_w.size() == 0) m_uf = 1'b1;
            else begin void'(mq_w.pop_back()); void'(mq_s.pop_back()); end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.ta_w = (mq_w.size() != 0) ? mq_w[mq_w.size()-1] : '0;
        e.ta_s = (mq_s.size() != 0) ? mq_s[mq_s.size()-1] : '0;
        e.n_w  = mq_w.size();
        e.n_s  = mq_s.size();
        e.ov_w = m_ov_w;
        e.ov_s = m_ov_s;
        e.uf   = m_uf;
        return e;
    endfunction

    // One clock: apply inputs, take the edge, record what both DUTs must show
    task automatic cyc(input logic p, input logic [AW-1:0] pc, input logic po, input logic fl);
        push = p; push_pc = pc; pop = po; flush = fl;
        @(posedge clk);
        #1;
        model_step(reset, p, pc, po, fl);
        exp_q.push_back(snapshot());
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    // Monitor: outputs are present every cycle; compare mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wrap_top_addr",  ta_w,  e.ta_w);
            check("wrap_top_valid", {31'b0, tv_w}, {31'b0, (e.n_w != 0)});
            check("wrap_count",     {29'b0, cnt_w}, AW'(e.n_w));
            check("wrap_overflow",  {31'b0, ov_w}, {31'b0, e.ov_w});
            check("wrap_underflow", {31'b0, uf_w}, {31'b0, e.uf});
            check("sat_top_addr",   ta_s,  e.ta_s);
            check("sat_top_valid",  {31'b0, tv_s}, {31'b0, (e.n_s != 0)});
            check("sat_count",      {29'b0, cnt_s}, AW'(e.n_s));
            check("sat_overflow",   {31'b0, ov_s}, {31'b0, e.ov_s});
            check("sat_underflow",  {31'b0, uf_s}, {31'b0, e.uf});
        end
    end

    initial begin
        int r;
        logic p, po, fl;
        logic [AW-1:0] pc;

        #1;
        check("reset_top_addr",  ta_w, 32'h0);
        check("reset_top_valid", {31'b0, tv_w}, 32'h0);
        check("reset_count",     {29'b0, cnt_s}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic LIFO order
        cyc(1, 32'h100, 0, 0);
        cyc(1, 32'h200, 0, 0);
        cyc(1, 32'h300, 0, 0);
        check("lifo_top", ta_w, 32'h304);
        check("lifo_count", {29'b0, cnt_w}, 32'd3);
        cyc(0, 0, 1, 0);
        check("lifo_pop1", ta_w, 32'h204);
        cyc(0, 0, 1, 0);
        check("lifo_pop2", ta_w, 32'h104);
        cyc(0, 0, 1, 0);
        check("lifo_empty", {31'b0, tv_w}, 32'h0);

        // Underflow pulse then clears
        cyc(0, 0, 1, 0);
        check("underflow_pulse", {31'b0, uf_w}, 32'h1);
        cyc(0, 0, 0, 0);
        check("underflow_clear", {31'b0, uf_w}, 32'h0);

        // Overflow under both policies
        for (int i = 0; i < 5; i++) cyc(1, AW'(i * 16), 0, 0);
        check("wrap_full_top", ta_w, 32'h44);
        check("sat_full_top",  ta_s, 32'h34);
        check("wrap_ovf",      {31'b0, ov_w}, 32'h1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);

        // Replace top, replace on empty, address wrap
        cyc(1, 32'h100, 0, 0);
        cyc(1, 32'h500, 1, 0);
        check("replace_top", ta_w, 32'h504);
        cyc(1, 32'hFFFF_FFFC, 0, 0);
        check("pc_wrap_top", ta_w, 32'h0);
        cyc(0, 0, 0, 1);
        cyc(1, 32'h700, 1, 0);
        check("replace_empty_count", {29'b0, cnt_w}, 32'd1);

        // Flush wins over a simultaneous push
        for (int i = 0; i < 5; i++) cyc(1, AW'(32'h1000 + i * 4), 0, 0);
        cyc(1, 32'h2000, 0, 1);
        check("flush_count", {29'b0, cnt_s}, 32'd0);
        check("flush_ovf",   {31'b0, ov_s}, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(0, 99));
            fl = (r < 3);
            p  = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            cyc(p, pc, po, fl);
        end

        // Asynchronous reset between edges
        cyc(1, 32'h40, 0, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_count", {29'b0, cnt_w}, 32'd0);
        check("async_rst_valid", {31'b0, tv_s}, 32'h0);
        check("async_rst_ovf",   {31'b0, ov_w}, 32'h0);
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        cyc(1, 32'h900, 0, 0);
        check("post_rst_push", ta_w, 32'h904);

        @(negedge clk);
        #1;
        check("scoreboard_drained", AW'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule : tb_return_addr_stack
`default_nettype wire
